// File: rtl/bitwise_logic_pipe.sv
// bitwise_logic_pipe
//   Pipelined bitwise logic unit. Each accepted transaction picks one of eight
//   2-input bitwise functions via i_in_op. The unit computes the result
//   combinationally and then passes it through a STAGES-deep valid/ready
//   pipeline. The pipeline supports backpressure and full throughput.
//
//   Ports
//     clk          rising-edge clock
//     rst_n        asynchronous active-low reset
//     i_in_valid   input transaction valid
//     o_in_ready   pipeline can accept input this cycle (comb. from i_out_ready)
//     i_in_op      function select: 0 NOR, 1 ANDN(~a&b), 2 AND, 3 OR,
//                  4 XOR, 5 XNOR, 6 NAND, 7 PASS_A
//     i_in_a       operand A
//     i_in_b       operand B
//     o_out_valid  result valid (last stage)
//     i_out_ready  downstream accepts result
//     o_out_data   result
//     o_out_op     op that produced o_out_data
//     o_out_cnt    count of completed output transfers (wraps silently)
module bitwise_logic_pipe #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [2:0]       i_in_op,
    input  logic [WIDTH-1:0] i_in_a,
    input  logic [WIDTH-1:0] i_in_b,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_data,
    output logic [2:0]       o_out_op,
    output logic [CNT_W-1:0] o_out_cnt
);

    logic [WIDTH-1:0]              w_result;
    logic [STAGES-1:0]             w_adv;
    logic [STAGES-1:0]             r_valid;
    logic [STAGES-1:0][WIDTH-1:0]  r_data;
    logic [STAGES-1:0][2:0]        r_op;
    logic [CNT_W-1:0]              r_cnt;

    always_comb begin
        w_result = i_in_a;
        case (i_in_op)
            3'd0:    w_result = ~(i_in_a | i_in_b);
            3'd1:    w_result = ~i_in_a & i_in_b;
            3'd2:    w_result = i_in_a & i_in_b;
            3'd3:    w_result = i_in_a | i_in_b;
            3'd4:    w_result = i_in_a ^ i_in_b;
            3'd5:    w_result = ~(i_in_a ^ i_in_b);
            3'd6:    w_result = ~(i_in_a & i_in_b);
            default: w_result = i_in_a;
        endcase
    end

    // A stage may advance when it or any stage downstream of it holds a bubble,
    // or when the output is being taken. The OR is accumulated from the output
    // side so that w_adv never reads itself.
    always_comb begin
        logic w_acc;
        w_acc = i_out_ready;
        w_adv = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_acc    = w_acc | ~r_valid[k];
            w_adv[k] = w_acc;
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        if (g == 0) begin : g_first
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid[0] <= 1'b0;
                    r_data[0]  <= '0;
                    r_op[0]    <= '0;
                end else if (w_adv[0]) begin
                    r_valid[0] <= i_in_valid;
                    // Payload only moves with a valid token, so idle inputs
                    // (possibly X) never reach the pipeline registers.
                    if (i_in_valid) begin
                        r_data[0] <= w_result;
                        r_op[0]   <= i_in_op;
                    end
                end
            end
        end else begin : g_next
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid[g] <= 1'b0;
                    r_data[g]  <= '0;
                    r_op[g]    <= '0;
                end else if (w_adv[g]) begin
                    r_valid[g] <= r_valid[g-1];
                    if (r_valid[g-1]) begin
                        r_data[g] <= r_data[g-1];
                        r_op[g]   <= r_op[g-1];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_valid[STAGES-1] && i_out_ready) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_in_ready  = w_adv[0];
    assign o_out_valid = r_valid[STAGES-1];
    assign o_out_data  = r_data[STAGES-1];
    assign o_out_op    = r_op[STAGES-1];
    assign o_out_cnt   = r_cnt;

endmodule
